cascaded_counter_bank: RTL and testbench
========================================

Name: cascaded_counter_bank

Overview:
Parametrised successor to the four-digit counter block. It is a chain of NUM_STAGES counters, each STAGE_WIDTH bits wide and modulo MODULUS, with carry/borrow rippling between stages. It adds up/down counting, synchronous clear, parallel load and a registered wrap flag. It sits behind the display/decoder logic as the general event or time counter, and its default configuration is a 4-digit BCD counter.

Parameters:
NUM_STAGES, 4, number of cascaded stages (1..8)
STAGE_WIDTH, 4, bits per stage
MODULUS, 10, count range per stage is 0..MODULUS-1; legal range 2..2**STAGE_WIDTH

Ports:
iClk  input  1  rising-edge clock
iRst  input  1  asynchronous reset, active-high
iEnable  input  1  count enable; one step per clock while high
iDir  input  1  1 = count up, 0 = count down
iClear  input  1  synchronous clear of all stages
iLoad  input  1  synchronous parallel load
iLoad_Value  input  NUM_STAGES*STAGE_WIDTH  load data; stage k occupies bits [k*STAGE_WIDTH +: STAGE_WIDTH]
oCount  output  NUM_STAGES*STAGE_WIDTH  stage values; stage 0 is least significant, same packing as iLoad_Value
oTerminal  output  1  combinational; high when the next enabled step wraps the whole chain
oWrap  output  1  registered one-cycle pulse, high in the cycle after a full-chain wrap

Behaviour:
- Reset: iRst high drives every stage and oWrap to 0 immediately, without waiting for a clock. While iRst is high all inputs are ignored. After iRst falls, the first active edge behaves normally.
- Priority at each rising edge: iClear > iLoad > iEnable count > hold.
- iClear: all stages go to 0. oWrap goes to 0 on the same edge.
- iLoad: each stage takes its slice of iLoad_Value. A slice >= MODULUS loads as 0 for that stage only. oWrap goes to 0.
- Count up (iEnable=1, iDir=1):
  - Stage 0 increments.
  - Stage k (k>0) steps only when stages 0..k-1 are all at MODULUS-1.
  - A stepping stage at MODULUS-1 wraps to 0.
- Count down (iEnable=1, iDir=0):
  - Stage 0 decrements.
  - Stage k (k>0) steps only when stages 0..k-1 are all 0.
  - A stepping stage at 0 wraps to MODULUS-1.
- Carry and borrow are resolved combinationally within the cycle. All stages update on the same edge, so the whole chain advances in one cycle with no ripple latency.
- oTerminal equals iEnable AND (up: every stage is MODULUS-1; down: every stage is 0). It is forced to 0 while iClear or iLoad is high.
- oWrap is a registered copy of oTerminal. It is high for exactly the one cycle following the wrap edge.
- iEnable=0 holds all stages. oWrap deasserts on the next edge.
- If iDir changes while iEnable is high, the new direction takes effect at the next edge. The chain does not glitch or skip a value.
- Width rule: stage arithmetic is done in STAGE_WIDTH+1 bits so there is no silent overflow when MODULUS = 2**STAGE_WIDTH (pure binary chain).

Optional Feature:
Macro COUNTER_BANK_SNAPSHOT_EN.
- When defined, two ports are added:
  - iSnap (input, 1): when high at an edge, the current pre-update oCount value is copied into the snapshot register.
  - oSnapshot (output, NUM_STAGES*STAGE_WIDTH): the snapshot register.
- oSnapshot resets to 0 on iRst. iClear does not affect it.
- An iSnap in the same cycle as iClear or iLoad captures the value before the clear or load.
- When the macro is undefined, both ports and the register are absent. Core behaviour is identical either way.

Test Plan:
- Reset mid-count: count to 0x0123, assert iRst asynchronously between edges -> oCount=0x0000 and oWrap=0 immediately; after release, counting resumes from 0.
- BCD carry, up: load 0x0999, iEnable=1, iDir=1, one edge -> oCount=0x1000. Load 0x9999, one edge -> oCount=0x0000, oTerminal was 1 before the edge, oWrap=1 for exactly one cycle.
- Down and borrow: load 0x1000, iDir=0, one edge -> 0x0999. From 0x0000, one edge -> 0x9999 and oWrap pulses.
- Priority: iClear=1, iLoad=1, iEnable=1 together at 0x0456 -> 0x0000. Then iLoad=1 with iEnable=1 and iLoad_Value=0x0C37 -> 0x0037, because the illegal stage slice C loads as 0.
- Enable gating: toggle iEnable pattern 5 high, 1 low, 5 high, 1 low, 5 high from 0 -> final oCount=0x0015, values held during the low cycles.
- Binary config (MODULUS=16, STAGE_WIDTH=4, NUM_STAGES=2): from 0xFF, one up edge -> 0x00 with oWrap pulse. With the macro defined, an iSnap at 0x7F followed by 3 counts -> oSnapshot=0x7F, oCount=0x82.

Source files
------------

// File: rtl/cascaded_counter_bank.sv
// cascaded_counter_bank
//   A chain of NUM_STAGES modulo-MODULUS counters, each STAGE_WIDTH bits wide,
//   with single-cycle carry/borrow propagation across the whole chain.
//   The default configuration is a 4-digit BCD counter.
//   Features: up/down count, synchronous clear, parallel load, combinational
//   terminal flag and a registered one-cycle wrap pulse.
//
// Optional feature macro: COUNTER_BANK_SNAPSHOT_EN
//   When defined, adds iSnap / oSnapshot.
//   On an edge with iSnap high, the pre-update oCount is captured.
//
// Ports
//   iClk         rising-edge clock
//   iRst         asynchronous reset, active-high (stages and oWrap -> 0)
//   iEnable      count enable, one step per clock
//   iDir         1 = up, 0 = down
//   iClear       synchronous clear (highest priority)
//   iLoad        synchronous parallel load from iLoad_Value
//   iLoad_Value  load data, stage k at [k*STAGE_WIDTH +: STAGE_WIDTH]
//   iSnap        (optional) capture current oCount into oSnapshot
//   oCount       stage values, stage 0 least significant
//   oSnapshot    (optional) snapshot register
//   oTerminal    high when the next enabled step wraps the whole chain
//   oWrap        one-cycle pulse in the cycle after a full-chain wrap

module cascaded_counter_bank #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_WIDTH = 4,
  parameter int unsigned MODULUS     = 10
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iEnable,
  input  logic                              iDir,
  input  logic                              iClear,
  input  logic                              iLoad,
  input  logic [NUM_STAGES*STAGE_WIDTH-1:0] iLoad_Value,
`ifdef COUNTER_BANK_SNAPSHOT_EN
  input  logic                              iSnap,
  output logic [NUM_STAGES*STAGE_WIDTH-1:0] oSnapshot,
`endif
  output logic [NUM_STAGES*STAGE_WIDTH-1:0] oCount,
  output logic                              oTerminal,
  output logic                              oWrap
);

  // Stage arithmetic is carried one bit wider than a stage so that
  // MODULUS = 2**STAGE_WIDTH (pure binary) neither overflows nor truncates.
  localparam logic [STAGE_WIDTH:0] MOD_W   = (STAGE_WIDTH+1)'(MODULUS);
  localparam logic [STAGE_WIDTH:0] MAX_W   = (STAGE_WIDTH+1)'(MODULUS - 1);
  localparam logic [STAGE_WIDTH:0] ONE_W   = (STAGE_WIDTH+1)'(1);
  localparam logic [STAGE_WIDTH-1:0] MAX_S = MAX_W[STAGE_WIDTH-1:0];

  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] count_q;
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] count_nxt;
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] load_slices;
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] load_fixed;
  logic [NUM_STAGES-1:0]                  at_max;
  logic [NUM_STAGES-1:0]                  at_min;
  logic [NUM_STAGES-1:0]                  step;
  logic                                   chain_wrap;
  logic                                   wrap_q;

  assign load_slices = iLoad_Value;

  // Per-stage boundary detection and load sanitising.
  always_comb begin
    at_max     = '0;
    at_min     = '0;
    load_fixed = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      at_max[k] = ({1'b0, count_q[k]} == MAX_W);
      at_min[k] = (count_q[k] == '0);
      // An out-of-range slice loads as 0 for that stage only.
      if ({1'b0, load_slices[k]} >= MOD_W) begin
        load_fixed[k] = '0;
      end else begin
        load_fixed[k] = load_slices[k];
      end
    end
  end

  // Carry/borrow ripple resolved combinationally: stage k steps when the
  // enable has survived every lower stage sitting at its boundary value.
  // Whatever survives past the top stage means the whole chain wraps.
  always_comb begin
    logic                   carry;
    logic [STAGE_WIDTH:0]   sum;
    step       = '0;
    count_nxt  = count_q;
    carry      = iEnable;
    sum        = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      step[k] = carry;
      if (iDir) begin
        carry = carry & at_max[k];
      end else begin
        carry = carry & at_min[k];
      end
    end
    chain_wrap = carry;

    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (step[k]) begin
        if (iDir) begin
          sum = {1'b0, count_q[k]} + ONE_W;
          if (sum >= MOD_W) begin
            count_nxt[k] = '0;
          end else begin
            count_nxt[k] = sum[STAGE_WIDTH-1:0];
          end
        end else begin
          if (at_min[k]) begin
            count_nxt[k] = MAX_S;
          end else begin
            count_nxt[k] = count_q[k] - STAGE_WIDTH'(1);
          end
        end
      end
    end
  end

  assign oTerminal = chain_wrap & ~iClear & ~iLoad;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (iClear) begin
        count_q <= '0;
      end else if (iLoad) begin
        count_q <= load_fixed;
      end else begin
        count_q <= count_nxt;
      end
      // oTerminal is already masked by clear/load, so this also clears the
      // pulse on those edges and when the enable drops.
      wrap_q <= oTerminal;
    end
  end

`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] snap_q;

  // Captures the pre-update value, so a snap coinciding with clear/load
  // sees the old count. Not affected by iClear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      snap_q <= '0;
    end else if (iSnap) begin
      snap_q <= count_q;
    end
  end

  assign oSnapshot = snap_q;
`endif

  assign oCount = count_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_cascaded_counter_bank.sv
module tb_cascaded_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default 4-digit BCD instance
  logic        rst, en, dir, clr, ld;
  logic [15:0] lv;
  logic [15:0] cnt;
  logic        term, wrap;

  // Binary 2x4-bit instance
  logic        b_en, b_dir, b_clr, b_ld;
  logic [7:0]  b_lv;
  logic [7:0]  b_cnt;
  logic        b_term, b_wrap;

`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic        snap, b_snap;
  logic [15:0] snapshot;
  logic [7:0]  b_snapshot;
`endif

  cascaded_counter_bank #(.NUM_STAGES(4), .STAGE_WIDTH(4), .MODULUS(10)) dut (
    .iClk(clk), .iRst(rst), .iEnable(en), .iDir(dir), .iClear(clr),
    .iLoad(ld), .iLoad_Value(lv),
`ifdef COUNTER_BANK_SNAPSHOT_EN
    .iSnap(snap), .oSnapshot(snapshot),
`endif
    .oCount(cnt), .oTerminal(term), .oWrap(wrap)
  );

  cascaded_counter_bank #(.NUM_STAGES(2), .STAGE_WIDTH(4), .MODULUS(16)) dut_bin (
    .iClk(clk), .iRst(rst), .iEnable(b_en), .iDir(b_dir), .iClear(b_clr),
    .iLoad(b_ld), .iLoad_Value(b_lv),
`ifdef COUNTER_BANK_SNAPSHOT_EN
    .iSnap(b_snap), .oSnapshot(b_snapshot),
`endif
    .oCount(b_cnt), .oTerminal(b_term), .oWrap(b_wrap)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t x;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: got %h expected <queued value>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: got %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  int e;

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; clr = 1'b0; ld = 1'b0; lv = '0;
    b_en = 1'b0; b_dir = 1'b1; b_clr = 1'b0; b_ld = 1'b0; b_lv = '0;
`ifdef COUNTER_BANK_SNAPSHOT_EN
    snap = 1'b0; b_snap = 1'b0;
`endif
    #2;
    push("reset_count", 16'h0000); check(cnt);
    push("reset_wrap", 16'h0000);  check({15'b0, wrap});
    tick();
    rst = 1'b0;

    // Reset mid-count
    ld = 1'b1; lv = 16'h0120; tick(); ld = 1'b0;
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push("count_to_0123", 16'h0120 + 16'(i)); tick(); check(cnt);
    end
    #2; rst = 1'b1; #1;
    push("async_rst_count", 16'h0000); check(cnt);
    push("async_rst_wrap", 16'h0000);  check({15'b0, wrap});
    tick();
    push("rst_held_ignores_en", 16'h0000); check(cnt);
    rst = 1'b0;
    push("resume_after_rst", 16'h0001); tick(); check(cnt);
    en = 1'b0;

    // BCD carry up
    ld = 1'b1; lv = 16'h0999; tick(); ld = 1'b0;
    push("load_0999", 16'h0999); check(cnt);
    en = 1'b1; dir = 1'b1; #1;
    push("term_0999", 16'h0000); check({15'b0, term});
    push("carry_1000", 16'h1000); tick(); check(cnt);
    en = 1'b0;
    ld = 1'b1; lv = 16'h9999; tick(); ld = 1'b0;
    en = 1'b1; #1;
    push("term_9999_up", 16'h0001); check({15'b0, term});
    tick();
    push("wrap_up_count", 16'h0000); check(cnt);
    push("wrap_up_pulse", 16'h0001); check({15'b0, wrap});
    tick();
    push("after_wrap_count", 16'h0001); check(cnt);
    push("wrap_one_cycle", 16'h0000);   check({15'b0, wrap});
    en = 1'b0;

    // Down and borrow
    ld = 1'b1; lv = 16'h1000; tick(); ld = 1'b0;
    en = 1'b1; dir = 1'b0;
    push("borrow_0999", 16'h0999); tick(); check(cnt);
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    push("clear_zero", 16'h0000); check(cnt);
    en = 1'b1; dir = 1'b0; #1;
    push("term_0000_down", 16'h0001); check({15'b0, term});
    tick();
    push("wrap_down_count", 16'h9999); check(cnt);
    push("wrap_down_pulse", 16'h0001); check({15'b0, wrap});
    en = 1'b0; tick();
    push("hold_9999", 16'h9999); check(cnt);
    push("wrap_drop", 16'h0000);  check({15'b0, wrap});

    // Priority
    ld = 1'b1; lv = 16'h0456; tick();
    push("load_0456", 16'h0456); check(cnt);
    clr = 1'b1; ld = 1'b1; en = 1'b1; dir = 1'b1; lv = 16'h1111;
    push("clr_over_load", 16'h0000); tick(); check(cnt);
    clr = 1'b0; lv = 16'h0C37;
    push("illegal_slice", 16'h0037); tick(); check(cnt);
    lv = 16'h9999; tick(); #1;
    push("term_masked_by_load", 16'h0000); check({15'b0, term});
    ld = 1'b0; en = 1'b0;

    // Enable gating 5/1/5/1/5
    clr = 1'b1; tick(); clr = 1'b0; dir = 1'b1;
    e = 0;
    for (int i = 0; i < 17; i++) begin
      en = (i == 5 || i == 11) ? 1'b0 : 1'b1;
      if (en) e++;
      tick();
      push("gating", bcd(e)); check(cnt);
    end
    push("gating_final", 16'h0015); check(cnt);
    // direction change takes effect on the next edge
    en = 1'b1; dir = 1'b0;
    push("dir_change", 16'h0014); tick(); check(cnt);
    en = 1'b0;

    // Binary configuration
    b_ld = 1'b1; b_lv = 8'hFF; tick(); b_ld = 1'b0;
    push("bin_load_ff", 16'h00FF); check({8'h0, b_cnt});
    b_en = 1'b1; b_dir = 1'b1; #1;
    push("bin_term", 16'h0001); check({15'b0, b_term});
    tick();
    push("bin_wrap_count", 16'h0000); check({8'h0, b_cnt});
    push("bin_wrap_pulse", 16'h0001); check({15'b0, b_wrap});
    b_en = 1'b0;
    b_ld = 1'b1; b_lv = 8'h7F; tick(); b_ld = 1'b0;
    b_en = 1'b1;
`ifdef COUNTER_BANK_SNAPSHOT_EN
    b_snap = 1'b1;
`endif
    tick();
`ifdef COUNTER_BANK_SNAPSHOT_EN
    b_snap = 1'b0;
`endif
    tick(); tick();
    b_en = 1'b0;
    push("bin_count_82", 16'h0082); check({8'h0, b_cnt});
`ifdef COUNTER_BANK_SNAPSHOT_EN
    push("bin_snapshot_7f", 16'h007F); check({8'h0, b_snapshot});
    clr = 1'b1; b_clr = 1'b1; snap = 1'b1; tick();
    clr = 1'b0; b_clr = 1'b0; snap = 1'b0;
    push("snap_before_clear", 16'h0014); check(snapshot);
    push("bin_snap_kept", 16'h007F);     check({8'h0, b_snapshot});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
